// File: rtl/up_bus_responder.sv
// FPGA-side responder for the async byte-wide uP handshake bus: 6-byte command in, one
// register-bank request, 8-byte reply out. Optional watchdog enabled by UP_TIMEOUT_EN.
`timescale 1ns/1ps
module up_bus_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int NOS_RX_BYTES   = 6,
  parameter int NOS_TX_BYTES   = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        async_uP_start,
  input  logic        async_uP_handshake_1,
  input  logic        async_uP_RW,
  inout  wire  [7:0]  uP_data,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  output logic [7:0]  reg_cmd,
  output logic [7:0]  reg_address,
  output logic [31:0] reg_wdata,
  output logic        reg_req,
  input  logic        reg_rsp_valid,
  input  logic [31:0] reg_rdata,
  input  logic [31:0] reg_status,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2((NOS_TX_BYTES > NOS_RX_BYTES) ? NOS_TX_BYTES : NOS_RX_BYTES);
  localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(NOS_RX_BYTES - 1);
  localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(NOS_TX_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RX_H1HI, S_RX_H1LO, S_EXEC, S_TX_SETUP, S_TX_H1HI, S_TX_H1LO, S_ACK
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] start_sync, h1_sync, rw_sync;
  logic                   start_s, h1_s, rw_s, start_d;
  logic [CNT_W-1:0]       count;
  logic                   ack_hold;
  logic                   tmo_hit;
  logic                   tx_drive;
  logic [7:0]             rx_buf [NOS_RX_BYTES];
  logic [63:0]            tx_sr;

  assign start_s = start_sync[SYNC_STAGES-1];
  assign h1_s    = h1_sync[SYNC_STAGES-1];
  assign rw_s    = rw_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_sync <= '0;
      h1_sync    <= '0;
      rw_sync    <= '0;
      start_d    <= 1'b0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], async_uP_start};
      h1_sync    <= {h1_sync[SYNC_STAGES-2:0], async_uP_handshake_1};
      rw_sync    <= {rw_sync[SYNC_STAGES-2:0], async_uP_RW};
      start_d    <= start_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (start_s && !start_d)  state_next = S_RX_H1HI;
      S_RX_H1HI:  if (h1_s && rw_s)         state_next = S_RX_H1LO;
      S_RX_H1LO:  if (!h1_s)                state_next = (count == RX_LAST) ? S_EXEC : S_RX_H1HI;
      S_EXEC:     if (reg_rsp_valid)        state_next = S_TX_SETUP;
      S_TX_SETUP: if (!h1_s && !rw_s)       state_next = S_TX_H1HI;
      S_TX_H1HI:  if (h1_s)                 state_next = S_TX_H1LO;
      S_TX_H1LO:  if (!h1_s)                state_next = (count == TX_LAST) ? S_ACK : S_TX_SETUP;
      S_ACK:      if (ack_hold && !start_s && !h1_s) state_next = S_IDLE;
      default:                              state_next = S_IDLE;
    endcase
    if (tmo_hit) state_next = S_IDLE;
  end

  // Outputs are registered from the next-state decode so they align with the state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count          <= '0;
      ack_hold       <= 1'b0;
      reg_req        <= 1'b0;
      uP_handshake_2 <= 1'b0;
      uP_ack         <= 1'b0;
      reg_cmd        <= '0;
      reg_address    <= '0;
      reg_wdata      <= '0;
    end else begin
      reg_req        <= (state_next == S_EXEC) && (state != S_EXEC);
      uP_handshake_2 <= (state_next == S_RX_H1LO) || (state_next == S_TX_H1HI);
      uP_ack         <= (state_next == S_ACK);
      ack_hold       <= (state == S_ACK);
      if (state_next == S_IDLE || (state == S_EXEC && state_next == S_TX_SETUP)) begin
        count <= '0;
      end else if ((state == S_RX_H1LO && state_next == S_RX_H1HI) ||
                   (state == S_TX_H1LO && state_next == S_TX_SETUP)) begin
        count <= count + 1'b1;
      end
      if (state == S_RX_H1LO && state_next == S_EXEC) begin
        reg_cmd     <= rx_buf[0];
        reg_address <= rx_buf[1];
        reg_wdata   <= {rx_buf[5], rx_buf[4], rx_buf[3], rx_buf[2]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_RX_H1HI && h1_s && rw_s) rx_buf[count] <= uP_data;
    if (state == S_EXEC && reg_rsp_valid) tx_sr <= {reg_status, reg_rdata};
    else if (state == S_TX_H1LO && !h1_s) tx_sr <= tx_sr >> 8;
  end

  // RW_s high always wins: the uP owns the bus whenever it says so
  assign tx_drive = ((state == S_TX_SETUP) || (state == S_TX_H1HI) || (state == S_TX_H1LO)) && !rw_s;
  assign uP_data  = tx_drive ? tx_sr[7:0] : 8'bz;

`ifdef UP_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err_q;

  assign tmo_hit     = (state != S_IDLE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (state_next != state)  tmo_cnt <= '0;
      else if (state != S_IDLE) tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
